// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared sizes, FSM states and element-slice helper for the 4x4 matmul
package matmul_pkg;

  localparam int N      = 4;
  localparam int DW_DEF = 8;
  localparam int RW_DEF = 2*DW_DEF + 2;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Row-major, MSB-first packing: element [0][0] sits in the top W bits.
  function automatic int elem_lsb(input int i, input int j, input int w);
    return w * (N*N - 1 - (N*i + j));
  endfunction

endpackage

// File: rtl/mat_mac.sv
// rtl/mat_mac.sv - combinational DW x DW multiply plus RW-bit accumulate with clear-select
module mat_mac #(
  parameter int DW = 8,
  parameter int RW = 2*DW + 2
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [RW-1:0] acc,
  input  logic          clr,
  output logic [RW-1:0] sum
);

  logic [2*DW-1:0] prod;

  assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  assign sum  = (clr ? '0 : acc) + {{(RW-2*DW){1'b0}}, prod};

endmodule

// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - sequential 4x4 matrix multiply driving one shared MAC over 64 cycles
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = 2*DW + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [16*DW-1:0] a_in,
  input  logic [16*DW-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [16*RW-1:0] res
);

  state_t          state, state_next;
  logic [5:0]      idx;
  logic [16*DW-1:0] a_reg, b_reg;
  logic [RW-1:0]   acc, acc_next;
  logic [DW-1:0]   a_m   [16];
  logic [DW-1:0]   b_m   [16];
  logic [RW-1:0]   res_m [16];

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign a_m[N*gi+gj] = a_reg[elem_lsb(gi, gj, DW) +: DW];
      assign b_m[N*gi+gj] = b_reg[elem_lsb(gi, gj, DW) +: DW];
      assign res[elem_lsb(gi, gj, RW) +: RW] = res_m[N*gi+gj];
    end
  end

  // idx = {i, j, k}: A is indexed by {i, k}, B by {k, j}.
  mat_mac #(.DW(DW), .RW(RW)) u_mac (
    .a   (a_m[{idx[5:4], idx[1:0]}]),
    .b   (b_m[{idx[1:0], idx[3:2]}]),
    .acc (acc),
    .clr (idx[1:0] == 2'd0),
    .sum (acc_next)
  );

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (idx == 6'd63) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      done  <= 1'b0;
      for (int e = 0; e < 16; e++) res_m[e] <= '0;
    end else begin
      done <= (state == RUN) && (idx == 6'd63);
      if (state == IDLE && start) begin
        a_reg <= a_in;
        b_reg <= b_in;
        idx   <= '0;
      end else if (state == RUN) begin
        acc <= acc_next;
        idx <= idx + 6'd1;
        if (idx[1:0] == 2'd3) res_m[idx[5:2]] <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - self-checking bench for matmul_seq_ctrl against a matrix-level model
module tb_matmul_seq_ctrl;

  localparam int DW = 8;
  localparam int RW = 2*DW + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [16*DW-1:0] a_in = '0;
  logic [16*DW-1:0] b_in = '0;
  logic             busy, done;
  logic [16*RW-1:0] res;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_c   [16];
  int m_res [16] = '{default: 0};
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_cnt  = 0;

  logic [16*RW-1:0] exp_res, tmp_r;
  int av [16];
  int bv [16];
  int n;

  always #5 clk = ~clk;

  matmul_seq_ctrl #(.DW(DW), .RW(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  function automatic int elem_of(input logic [16*DW-1:0] m, input int e);
    logic [16*DW-1:0] t;
    t = m >> (DW*(15-e));
    return int'(t[DW-1:0]);
  endfunction

  function automatic int res_elem(input int e);
    logic [16*RW-1:0] t;
    t = res >> (RW*(15-e));
    return int'(t[RW-1:0]);
  endfunction

  function automatic logic [16*DW-1:0] pack(input int v[16]);
    logic [16*DW-1:0] p, t;
    p = '0;
    for (int e = 0; e < 16; e++) begin
      t = '0;
      t[DW-1:0] = v[e][DW-1:0];
      p |= t << (DW*(15-e));
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [16*RW-1:0] act, input logic [16*RW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Matrix-level model: C is computed at acceptance, then revealed one element every 4 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      for (int e = 0; e < 16; e++) m_res[e] = 0;
    end else if (m_busy) begin
      m_cnt++;
      m_done = 1'b0;
      if (m_cnt % 4 == 0) m_res[m_cnt/4-1] = m_c[m_cnt/4-1];
      if (m_cnt == 64) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            m_c[4*i+j] = 0;
            for (int k = 0; k < 4; k++)
              m_c[4*i+j] += elem_of(a_in, 4*i+k) * elem_of(b_in, 4*k+j);
          end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_res = '0;
      for (int e = 0; e < 16; e++) begin
        tmp_r = '0;
        tmp_r[RW-1:0] = m_res[e][RW-1:0];
        exp_res |= tmp_r << (RW*(15-e));
      end
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("res", res, exp_res);
    end
  end

  task automatic start_op(input logic [16*DW-1:0] a, input logic [16*DW-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    repeat (10) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_res", res, 0);

    for (int e = 0; e < 16; e++) begin
      av[e] = e + 1;
      bv[e] = e + 17;
    end
    start_op(pack(av), pack(bv));
    wait_done(n);
    check("latency", n, 64);
    check("c00", res_elem(0), 250);
    check("c01", res_elem(1), 260);
    check("c33", res_elem(15), 1528);

    for (int e = 0; e < 16; e++) av[e] = (e / 4 == e % 4) ? 1 : 0;
    start_op(pack(av), pack(bv));
    wait_done(n);
    check("b2b_gap", n + 1, 65);
    for (int e = 0; e < 16; e++) check("ident", res_elem(e), e + 17);

    for (int e = 0; e < 16; e++) av[e] = 255;
    start_op(pack(av), pack(av));
    wait_done(n);
    for (int e = 0; e < 16; e++) check("full", res_elem(e), 260100);

    for (int e = 0; e < 16; e++) av[e] = e + 1;
    start_op(pack(av), pack(bv));
    repeat (20) @(negedge clk);
    check("mid_busy", busy, 1);
    a_in  = {16{8'hff}};
    b_in  = {16{8'h55}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("mid_latency", n, 43);
    check("mid_c00", res_elem(0), 250);
    check("mid_c33", res_elem(15), 1528);

    for (int e = 0; e < 16; e++) bv[e] = 32 - e;
    start_op(pack(av), pack(bv));
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(pack(av), pack(bv));
    wait_done(n);
    check("post_rst_latency", n, 64);
    check("post_rst_c00", res_elem(0), 240);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
